// File: rtl/fifo_word_packer.sv
// fifo_word_packer: reads PACK_BYTES FIFO entries and presents them as one little-endian word on valid/ready.
// Define PACK_FLUSH_EN to add the flush input and out_cnt output, which allow a partial word to be emitted.
module fifo_word_packer #(
  parameter int DATA_WIDTH = 8,
  parameter int PACK_BYTES = 4
) (
  input  logic                               clk,
  input  logic                               reset_n,
`ifdef PACK_FLUSH_EN
  input  logic                               flush,
  output logic [$clog2(PACK_BYTES+1)-1:0]    out_cnt,
`endif
  output logic                               rd_en,
  input  logic [DATA_WIDTH-1:0]              rd_data,
  input  logic                               rd_val,
  output logic [PACK_BYTES*DATA_WIDTH-1:0]   out_data,
  output logic                               out_valid,
  input  logic                               out_ready
);
  localparam int CW = $clog2(PACK_BYTES + 1);
  typedef enum logic {ACCUM, HOLD} state_t;
  state_t                           r_state;
  logic [CW-1:0]                    r_cnt;
  logic                             r_pending;
  logic [PACK_BYTES*DATA_WIDTH-1:0] r_data;
  logic                             r_valid;
  logic                             w_take;
  logic                             w_last;
  logic [CW:0]                      w_fill;
  logic                             w_block;
  assign w_take = r_pending & rd_val;
  assign w_last = r_cnt == CW'(PACK_BYTES - 1);
  assign w_fill = {1'b0, r_cnt} + (CW+1)'(r_pending);
`ifdef PACK_FLUSH_EN
  logic          r_flush_req;
  logic [CW-1:0] r_out_cnt;
  assign w_block = r_flush_req;
  assign out_cnt = r_out_cnt;
`else
  assign w_block = 1'b0;
`endif
  // rd_val is only trusted the cycle after our own rd_en, so stale FIFO valids never count
  assign rd_en     = reset_n && r_state == ACCUM && w_fill < (CW+1)'(PACK_BYTES) && !w_block;
  assign out_data  = r_data;
  assign out_valid = r_valid;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ACCUM;
      r_cnt     <= '0;
      r_pending <= 1'b0;
      r_data    <= '0;
      r_valid   <= 1'b0;
`ifdef PACK_FLUSH_EN
      r_flush_req <= 1'b0;
      r_out_cnt   <= '0;
`endif
    end else begin
      r_pending <= rd_en;
      if (r_state == ACCUM) begin
        if (w_take) begin
          for (int i = 0; i < PACK_BYTES; i++)
            if (r_cnt == CW'(i)) r_data[i*DATA_WIDTH +: DATA_WIDTH] <= rd_data;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_state <= HOLD;
            r_valid <= 1'b1;
          end
        end
`ifdef PACK_FLUSH_EN
        if (w_take && w_last) begin
          r_flush_req <= 1'b0;
          r_out_cnt   <= CW'(PACK_BYTES);
        end else if (r_flush_req && !r_pending) begin
          r_flush_req <= 1'b0;
          if (r_cnt != '0) begin
            r_state   <= HOLD;
            r_valid   <= 1'b1;
            r_out_cnt <= r_cnt;
          end
        end else if (flush && (r_cnt != '0 || r_pending)) begin
          r_flush_req <= 1'b1;
        end
`endif
      end else if (r_valid && out_ready) begin
        r_valid <= 1'b0;
        r_cnt   <= '0;
        r_data  <= '0;
        r_state <= ACCUM;
      end
    end
  end
endmodule

// File: tb/tb_fifo_word_packer.sv
// tb_fifo_word_packer: directed bench for fifo_word_packer with a 1-cycle-latency byte FIFO model that holds stale rd_val.
module tb_fifo_word_packer;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        rd_en;
  logic [7:0]  rd_data = '0;
  logic        rd_val = 1'b0;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  int          n_checks = 0;
  int          n_errors = 0;
  logic [7:0]  fifo[$];
  logic [31:0] words[$];
`ifdef PACK_FLUSH_EN
  logic        flush = 1'b0;
  logic [2:0]  out_cnt;
  logic [2:0]  cnts[$];
`endif

  fifo_word_packer #(.DATA_WIDTH(8), .PACK_BYTES(4)) dut (
    .clk(clk),
    .reset_n(reset_n),
`ifdef PACK_FLUSH_EN
    .flush(flush),
    .out_cnt(out_cnt),
`endif
    .rd_en(rd_en),
    .rd_data(rd_data),
    .rd_val(rd_val),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  // FIFO model: rd_val/rd_data only change on a read, so they go stale while rd_en is low
  always @(posedge clk)
    if (rd_en) begin
      if (fifo.size() > 0) begin
        rd_data <= fifo.pop_front();
        rd_val  <= 1'b1;
      end else begin
        rd_val <= 1'b0;
      end
    end

  always @(posedge clk)
    if (out_valid && out_ready) begin
      words.push_back(out_data);
`ifdef PACK_FLUSH_EN
      cnts.push_back(out_cnt);
`endif
    end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_seq(input logic [7:0] first, input logic [7:0] step, input int n);
    for (int i = 0; i < n; i++) fifo.push_back(first + 8'(i) * step);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    fifo.delete();
    words.delete();
`ifdef PACK_FLUSH_EN
    cnts.delete();
`endif
    repeat (2) @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_rd_en", rd_en, 0);
  endtask

  task automatic wait_word(input string tag, input int n);
    int k = 0;
    while (!out_valid && k < n) begin
      @(negedge clk);
      k++;
    end
    chk(tag, out_valid, 1);
  endtask

  initial begin
    bit e_rd[7] = '{1, 1, 1, 1, 0, 0, 1};
    bit e_v[7]  = '{0, 0, 0, 0, 0, 1, 0};
    // preloaded FIFO: exact cycle-by-cycle rd_en / out_valid pattern
    do_reset();
    push_seq(8'h11, 8'h11, 4);
    out_ready = 1'b1;
    reset_n = 1'b1;
    #1;
    for (int k = 0; k < 7; k++) begin
      chk($sformatf("t1_rd_en_%0d", k), rd_en, e_rd[k]);
      chk($sformatf("t1_valid_%0d", k), out_valid, e_v[k]);
      if (k == 5) begin
        chk("t1_data", out_data, 32'h44332211);
`ifdef PACK_FLUSH_EN
        chk("t1_out_cnt", out_cnt, 4);
`endif
      end
      @(negedge clk);
    end
    chk("t1_words", words.size(), 1);

    // empty FIFO trickle-fed one byte per 3 cycles
    do_reset();
    out_ready = 1'b1;
    reset_n = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("t2_retry_%0d", k), rd_en, 1);
      @(negedge clk);
    end
    for (int i = 0; i < 4; i++) begin
      repeat (3) @(negedge clk);
      fifo.push_back(8'hA1 + 8'(i));
    end
    wait_word("t2_wait", 30);
    repeat (10) @(negedge clk);
    chk("t2_words", words.size(), 1);
    chk("t2_data", words.size() > 0 ? words[0] : 32'h0, 32'hA4A3A2A1);
    chk("t2_fifo_left", fifo.size(), 0);

    // back-pressure: word held stable with no reads
    do_reset();
    push_seq(8'h01, 8'h01, 8);
    out_ready = 1'b0;
    reset_n = 1'b1;
    wait_word("t3_wait", 20);
    for (int k = 0; k < 10; k++) begin
      chk("t3_hold_data", out_data, 32'h04030201);
      chk("t3_hold_valid", out_valid, 1);
      chk("t3_hold_rd_en", rd_en, 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    repeat (12) @(negedge clk);
    chk("t3_words", words.size(), 2);
    chk("t3_w0", words.size() > 0 ? words[0] : 32'h0, 32'h04030201);
    chk("t3_w1", words.size() > 1 ? words[1] : 32'h0, 32'h08070605);

    // reset mid-word: 0x21,0x22 accepted, 0x23 in flight and lost
    do_reset();
    push_seq(8'h21, 8'h01, 8);
    out_ready = 1'b1;
    reset_n = 1'b1;
    #1;
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("t4_rst_valid", out_valid, 0);
    chk("t4_rst_rd_en", rd_en, 0);
    chk("t4_rst_data", out_data, 0);
    @(negedge clk);
    reset_n = 1'b1;
    wait_word("t4_wait", 20);
    repeat (3) @(negedge clk);
    chk("t4_words", words.size(), 1);
    chk("t4_data", words.size() > 0 ? words[0] : 32'h0, 32'h27262524);

    // stale rd_val=1 held through HOLD and the first rd_en after handshake
    do_reset();
    push_seq(8'h51, 8'h01, 4);
    out_ready = 1'b0;
    reset_n = 1'b1;
    wait_word("t5_wait", 20);
    repeat (10) @(negedge clk);
    push_seq(8'h61, 8'h01, 4);
    out_ready = 1'b1;
    repeat (15) @(negedge clk);
    chk("t5_words", words.size(), 2);
    chk("t5_w0", words.size() > 0 ? words[0] : 32'h0, 32'h54535251);
    chk("t5_w1", words.size() > 1 ? words[1] : 32'h0, 32'h64636261);

`ifdef PACK_FLUSH_EN
    // partial word flush, then a flush with nothing collected
    do_reset();
    push_seq(8'hB1, 8'h01, 3);
    out_ready = 1'b1;
    reset_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("t6_no_word", words.size(), 0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    wait_word("t6_wait", 10);
    chk("t6_data", out_data, 32'h00B3B2B1);
    chk("t6_out_cnt", out_cnt, 3);
    repeat (3) @(negedge clk);
    chk("t6_words", words.size(), 1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    repeat (10) @(negedge clk);
    chk("t6_empty_flush", words.size(), 1);
    chk("t6_empty_valid", out_valid, 0);
    push_seq(8'hC1, 8'h01, 4);
    repeat (15) @(negedge clk);
    chk("t6_words2", words.size(), 2);
    chk("t6_full", words.size() > 1 ? words[1] : 32'h0, 32'hC4C3C2C1);
    chk("t6_full_cnt", cnts.size() > 1 ? cnts[1] : 3'd0, 4);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
